apb_master: RTL and testbench

//   APB initiator for the I2C-APB subsystem; drives the bus that the apb slave/FIFO bridge responds to.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_wait_timer.sv | 47 ++++
 rtl/apb_master.sv | 162 ++++++++++++++++
 tb/tb_apb_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB initiator.
//   - apb_state_e      : FSM state encoding (IDLE, SETUP, ACCESS)
//   - APB_ADDR_WIDTH   : default address width
//   - APB_DATA_WIDTH   : default data width
//   - tmo_cnt_width()  : width of the wait-state timeout counter
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts consecutive APB wait states and flags the one that exhausts the budget.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   asynchronous active-low reset
//   clear_i   in   restart the count from zero (transfer entering ACCESS)
//   count_i   in   one more wait state is being spent this cycle
//   expire_o  out  this cycle's wait state is number LIMIT; the transfer must be abandoned
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CntW = tmo_cnt_width(LIMIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires combinationally on the wait cycle whose edge brings the count to LIMIT,
    // so the FSM leaves ACCESS after exactly LIMIT stalled cycles.
    assign expire_o = count_i && (cnt_q == LastCnt);

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator driven by a valid/ready command port.
// Optional feature: define APB_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES
// consecutive wait states (response flagged with rsp_err). Undefined: waits forever.
// Ports:
//   PCLK, PRESETn          bus clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata   command fields, captured at the accepting edge
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata/rsp_err      read data (0 for writes/timeouts) and timeout flag, held between pulses
//   PSELx/PENABLE/PWRITE   APB control
//   PADDR/PWDATA           APB address / write data, held stable for the whole transfer
//   PRDATA/PREADY          APB slave read data and ready
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be >= 1");
    end

    apb_state_e state_q, state_d;

    logic                  accept;
    logic                  done;
    logic                  abort;
    logic                  tmo_expire;

    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    assign accept = cmd_valid && cmd_ready;
    assign done   = (state_q == ACCESS) && PREADY;
    // Completion takes priority: timeout only counts when PREADY is still low.
    assign abort  = (state_q == ACCESS) && !PREADY && tmo_expire;

`ifdef APB_TIMEOUT_EN
    logic rsp_err_q;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .clear_i  (state_q == SETUP),
        .count_i  ((state_q == ACCESS) && !PREADY),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_err_q <= 1'b0;
        end else if (done) begin
            rsp_err_q <= 1'b0;
        end else if (abort) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo_expire = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        cmd_ready = 1'b0;
        PSELx     = 1'b0;
        PENABLE   = 1'b0;
        unique case (state_q)
            IDLE:   cmd_ready = 1'b1;
            SETUP:  PSELx     = 1'b1;
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- APB transfer registers
    // Loaded only on accept, so they stay put through SETUP/ACCESS and keep last values in IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
        end
    end

    assign PWRITE = pwrite_q;
    assign PADDR  = paddr_q;
    assign PWDATA = pwdata_q;

    // ---------------------------------------------------------------- response registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done || abort;
            if (done) begin
                rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            end else if (abort) begin
                rsp_rdata_q <= '0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset;
        #3;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (PSELx !== 1'b0) begin n_fail++; $display("FAIL rst_psel got=%b exp=0", PSELx); end
        n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_penable got=%b exp=0", PENABLE); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
        n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_rdata got=%h exp=00", rsp_rdata); end
        n_checks++; if ({PWRITE, PADDR, PWDATA} !== 17'h0) begin n_fail++;
            $display("FAIL rst_bus got=%b/%h/%h exp=0/00/00", PWRITE, PADDR, PWDATA); end
        tick;
        PRESETn = 1'b1;
        tick;
    endtask

    task automatic test_write_zero_wait;
        PREADY = 1'b1;
        issue(1'b1, 8'h00, 8'h55);
        tick;  // accept
        n_checks++; if ({PSELx, PENABLE} !== 2'b10) begin n_fail++; $display("FAIL wr_setup_ctl got=%b exp=10", {PSELx, PENABLE}); end
        n_checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 8'h00, 8'h55}) begin n_fail++;
            $display("FAIL wr_setup_bus got=%b/%h/%h exp=1/00/55", PWRITE, PADDR, PWDATA); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_setup_ready got=%b exp=0", cmd_ready); end
        cmd_valid = 1'b0;
        tick;
        n_checks++; if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin n_fail++;
            $display("FAIL wr_access got=%b exp=110", {PSELx, PENABLE, rsp_valid}); end
        tick;
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h00}) begin n_fail++;
            $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/00", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if ({PSELx, PENABLE, cmd_ready} !== 3'b001) begin n_fail++;
            $display("FAIL wr_done_ctl got=%b exp=001", {PSELx, PENABLE, cmd_ready}); end
        tick;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse got=%b exp=0", rsp_valid); end
        n_checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 8'h00, 8'h55}) begin n_fail++;
            $display("FAIL wr_idle_hold got=%b/%h/%h exp=1/00/55", PWRITE, PADDR, PWDATA); end
    endtask

    task automatic test_read_waits;
        PREADY = 1'b0;
        PRDATA = 8'hAA;
        issue(1'b0, 8'h04, 8'hFF);
        tick;
        n_checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b0, 8'h04, 8'h00}) begin n_fail++;
            $display("FAIL rd_setup_bus got=%b/%h/%h exp=0/04/00", PWRITE, PADDR, PWDATA); end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if ({PENABLE, rsp_valid} !== 2'b10) begin n_fail++;
                $display("FAIL rd_access%0d got=%b exp=10", i, {PENABLE, rsp_valid}); end
            if (i == 2) begin
                PREADY = 1'b1;
                PRDATA = 8'h55;
            end
        end
        tick;
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h55}) begin n_fail++;
            $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/55", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL rd_done_penable got=%b exp=0", PENABLE); end
        PRDATA = 8'hAA;
        tick;
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h55}) begin n_fail++;
            $display("FAIL rd_rsp_hold got=%b/%h exp=0/55", rsp_valid, rsp_rdata); end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout;
        PREADY = 1'b0;
        PRDATA = 8'h77;
        issue(1'b0, 8'h60, 8'h00);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if ({PENABLE, rsp_valid} !== 2'b10) begin n_fail++;
                $display("FAIL tmo_access%0d got=%b exp=10", i, {PENABLE, rsp_valid}); end
        end
        tick;
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 8'h00}) begin n_fail++;
            $display("FAIL tmo_rsp got=%b/%b/%h exp=1/1/00", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if ({PSELx, PENABLE, cmd_ready} !== 3'b001) begin n_fail++;
            $display("FAIL tmo_ctl got=%b exp=001", {PSELx, PENABLE, cmd_ready}); end
        tick;
        n_checks++; if ({rsp_valid, rsp_err} !== 2'b01) begin n_fail++;
            $display("FAIL tmo_hold got=%b exp=01", {rsp_valid, rsp_err}); end
        PREADY = 1'b1;
    endtask
`else
    task automatic test_no_timeout;
        PREADY = 1'b0;
        PRDATA = 8'h77;
        issue(1'b0, 8'h60, 8'h00);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            n_checks++; if ({PENABLE, rsp_valid} !== 2'b10) begin n_fail++;
                $display("FAIL ntmo_access%0d got=%b exp=10", i, {PENABLE, rsp_valid}); end
        end
        PREADY = 1'b1;
        tick;
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h77}) begin n_fail++;
            $display("FAIL ntmo_rsp got=%b/%b/%h exp=1/0/77", rsp_valid, rsp_err, rsp_rdata); end
    endtask
`endif

    task automatic test_back_to_back;
        PREADY = 1'b1;
        issue(1'b1, 8'h10, 8'h11);
        tick;
        n_checks++; if (PADDR !== 8'h10) begin n_fail++; $display("FAIL b2b_setup1 got=%h exp=10", PADDR); end
        issue(1'b1, 8'h20, 8'h22);
        tick;
        n_checks++; if ({PENABLE, PADDR, PWDATA} !== {1'b1, 8'h10, 8'h11}) begin n_fail++;
            $display("FAIL b2b_access1 got=%b/%h/%h exp=1/10/11", PENABLE, PADDR, PWDATA); end
        tick;
        n_checks++; if ({PSELx, rsp_valid, cmd_ready} !== 3'b011) begin n_fail++;
            $display("FAIL b2b_idle got=%b exp=011", {PSELx, rsp_valid, cmd_ready}); end
        n_checks++; if (PADDR !== 8'h10) begin n_fail++; $display("FAIL b2b_idle_addr got=%h exp=10", PADDR); end
        tick;
        n_checks++; if ({PSELx, PENABLE, PADDR, PWDATA} !== {2'b10, 8'h20, 8'h22}) begin n_fail++;
            $display("FAIL b2b_setup2 got=%b%b/%h/%h exp=10/20/22", PSELx, PENABLE, PADDR, PWDATA); end
        cmd_valid = 1'b0;
        tick;
        tick;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp2 got=%b exp=1", rsp_valid); end
        tick;
    endtask

    task automatic test_busy_holdoff;
        PREADY = 1'b0;
        issue(1'b0, 8'h30, 8'h00);
        tick;
        issue(1'b1, 8'h40, 8'h99);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_setup_ready got=%b exp=0", cmd_ready); end
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++; if ({cmd_ready, PWRITE, PADDR} !== {2'b00, 8'h30}) begin n_fail++;
                $display("FAIL busy_access%0d got=%b/%b/%h exp=0/0/30", i, cmd_ready, PWRITE, PADDR); end
        end
        PREADY = 1'b1;
        PRDATA = 8'h3C;
        tick;
        n_checks++; if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 8'h3C, 1'b1}) begin n_fail++;
            $display("FAIL busy_rsp1 got=%b/%h/%b exp=1/3c/1", rsp_valid, rsp_rdata, cmd_ready); end
        tick;
        n_checks++; if ({PSELx, PWRITE, PADDR, PWDATA} !== {2'b11, 8'h40, 8'h99}) begin n_fail++;
            $display("FAIL busy_setup2 got=%b%b/%h/%h exp=11/40/99", PSELx, PWRITE, PADDR, PWDATA); end
        cmd_valid = 1'b0;
        tick;
        tick;
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h00}) begin n_fail++;
            $display("FAIL busy_rsp2 got=%b/%h exp=1/00", rsp_valid, rsp_rdata); end
        tick;
    endtask

    task automatic test_reset_mid;
        PREADY = 1'b0;
        issue(1'b1, 8'h50, 8'h66);
        tick;
        cmd_valid = 1'b0;
        tick;
        n_checks++; if (PENABLE !== 1'b1) begin n_fail++; $display("FAIL rstm_in_access got=%b exp=1", PENABLE); end
        #2;
        PRESETn = 1'b0;
        #1;
        n_checks++; if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin n_fail++;
            $display("FAIL rstm_abort got=%b exp=0001", {PSELx, PENABLE, rsp_valid, cmd_ready}); end
        n_checks++; if (PADDR !== 8'h00) begin n_fail++; $display("FAIL rstm_addr got=%h exp=00", PADDR); end
        tick;
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if ({PSELx, rsp_valid, cmd_ready} !== 3'b001) begin n_fail++;
                $display("FAIL rstm_after%0d got=%b exp=001", i, {PSELx, rsp_valid, cmd_ready}); end
        end
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;

        test_reset;
        test_write_zero_wait;
        test_read_waits;
`ifdef APB_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_back_to_back;
        test_busy_holdoff;
        test_reset_mid;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
